rdn_in_unit: RTL and testbench

- Receiving end of the HEU → RDN interface.
- Captures one equalized 20x20 sub-image from the HEU in a single handshake cycle. The image arrives as a 5x80 pixel array.
- Holds up to two images in a ping-pong buffer.
- Streams each image to the RDN neuron array one 20-pixel image row per beat, using a valid/ready handshake.

---
 rtl/rdn_in_unit_if.sv | 23 ++
 rtl/rdn_in_unit.sv | 90 +++++++++
 tb/tb_rdn_in_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rdn_in_unit_if.sv
// rtl/rdn_in_unit_if.sv - HEU image input and RDN row output bundle for rdn_in_unit
interface rdn_in_unit_if #(
    parameter int DATA_W = 8
);
    logic                            heu_out_ready;
    logic [4:0][79:0][DATA_W-1:0]    d;
    logic                            in_ready;
    logic                            out_valid;
    logic                            out_ready;
    logic [19:0][DATA_W-1:0]         q;
    logic [4:0]                      q_row;
    logic                            q_last;

    modport master (
        output heu_out_ready, d, out_ready,
        input  in_ready, out_valid, q, q_row, q_last
    );

    modport slave (
        input  heu_out_ready, d, out_ready,
        output in_ready, out_valid, q, q_row, q_last
    );
endinterface

// File: rtl/rdn_in_unit.sv
// rtl/rdn_in_unit.sv - ping-pong image buffer from HEU, streamed to RDN one row per beat
module rdn_in_unit #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rdn_in_unit_if.slave  bus
);
    typedef logic [19:0][DATA_W-1:0]        row_t;
    typedef logic [19:0][19:0][DATA_W-1:0]  img_t;

    localparam logic [4:0] LAST_ROW = 5'd19;

    img_t        bank [0:1];
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [4:0]  row_cnt;

    logic        in_ready;
    logic        out_valid;
    logic        wr_fire;
    logic        rd_fire;
    logic        last_beat;
    img_t        img_in;
    row_t        row_sel;

    // The HEU packs pixel p = r*80 + c and the image wants p = y*20 + x; both
    // are row-major over the same 400 pixels, so the bit layouts coincide.
    assign img_in = bus.d;

    // Flow control depends on registered state only, never on out_ready.
    assign in_ready  = !full[wr_ptr];
    assign out_valid = full[rd_ptr];

    assign wr_fire   = bus.heu_out_ready && in_ready;
    assign rd_fire   = out_valid && bus.out_ready;
    assign last_beat = rd_fire && (row_cnt == LAST_ROW);

    assign row_sel   = bank[rd_ptr][row_cnt];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.q         = out_valid ? row_sel : '0;
    assign bus.q_row     = row_cnt;
    assign bus.q_last    = (row_cnt == LAST_ROW);

    // Next occupancy: a capture and a final-row beat in the same cycle always
    // touch different banks, since a capture requires its bank to be empty.
    always_comb begin
        full_nxt = full;
        if (wr_fire) begin
            full_nxt[wr_ptr] = 1'b1;
        end
        if (last_beat) begin
            full_nxt[rd_ptr] = 1'b0;
        end
    end

    // Occupancy, pointers and row counter; reset discards buffered images.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            row_cnt <= 5'd0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_fire) begin
                if (row_cnt == LAST_ROW) begin
                    row_cnt <= 5'd0;
                    rd_ptr  <= ~rd_ptr;
                end else begin
                    row_cnt <= row_cnt + 5'd1;
                end
            end
        end
    end

    // Image storage needs no reset; a bank is only read while marked full.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank[wr_ptr] <= img_in;
        end
    end
endmodule

// File: tb/tb_rdn_in_unit.sv
// tb/tb_rdn_in_unit.sv - scoreboard bench for rdn_in_unit
module tb_rdn_in_unit;
    localparam int W = 8;

    typedef logic [4:0][79:0][W-1:0] img_t;
    typedef logic [19:0][W-1:0]      row_t;
    typedef struct {
        row_t       q;
        logic [4:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rdn_in_unit_if #(.DATA_W(W)) bus();

    rdn_in_unit #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push_map(input img_t img);
        exp_t e;
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 20; x++) begin
                e.q[x] = img[y / 4][(y % 4) * 20 + x];
            end
            e.r = 5'(y);
            sb.push_back(e);
        end
    endfunction

    function automatic img_t fill(input logic [7:0] v);
        img_t img;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 80; c++)
                img[r][c] = v;
        return img;
    endfunction

    task automatic capture(input img_t img, input logic exp_acc);
        bus.d = img;
        bus.heu_out_ready = 1'b1;
        @(negedge clk);
        chk("capture_in_ready", 160'(bus.in_ready), 160'(exp_acc));
        step(1);
        bus.heu_out_ready = 1'b0;
    endtask

    // Monitor: compare the presented row with the scoreboard head every cycle,
    // retire the head only on an accepted beat (so stalls must hold the row).
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_row act_row=%0d exp=none t=%0t", bus.q_row, $time);
                end else begin
                    mon_e = sb[0];
                    chk("row_data", 160'(bus.q), 160'(mon_e.q));
                    chk("q_row", 160'(bus.q_row), 160'(mon_e.r));
                    chk("q_last", 160'(bus.q_last), 160'(mon_e.r == 5'd19));
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("q_idle_zero", 160'(bus.q), 160'(0));
            end
        end
    end

    img_t       img_a, img_b, img_c, img_corner;
    exp_t       e;
    logic [3:0] pat;

    initial begin
        bus.heu_out_ready = 1'b0;
        bus.out_ready = 1'b0;
        bus.d = '0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 160'(bus.in_ready), 160'(1));
        chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
        chk("rst_q_row", 160'(bus.q_row), 160'(0));
        chk("rst_q_last", 160'(bus.q_last), 160'(0));
        chk("rst_q", 160'(bus.q), 160'(0));
        step(1);
        rst_n = 1'b1;
        step(1);

        // single ramp image, pixel p = p mod 256
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 80; c++)
                img_a[r][c] = 8'((r * 80 + c) & 255);
        bus.out_ready = 1'b1;
        capture(img_a, 1'b1);
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 20; x++) e.q[x] = 8'((y * 20 + x) & 255);
            e.r = 5'(y);
            sb.push_back(e);
        end
        @(negedge clk);
        chk("single_latency_valid", 160'(bus.out_valid), 160'(1));
        chk("single_first_row", 160'(bus.q_row), 160'(0));
        chk("single_in_ready", 160'(bus.in_ready), 160'(1));
        step(21);
        @(negedge clk);
        chk("single_done_valid", 160'(bus.out_valid), 160'(0));
        chk("single_drained", 160'(sb.size()), 160'(0));
        step(1);

        // ping-pong fill: A, B accepted; C refused until A drains
        bus.out_ready = 1'b0;
        img_a = fill(8'h11);
        img_b = fill(8'h22);
        img_c = fill(8'h33);
        capture(img_a, 1'b1);
        push_map(img_a);
        capture(img_b, 1'b1);
        push_map(img_b);
        capture(img_c, 1'b0);
        bus.d = img_c;
        bus.heu_out_ready = 1'b1;
        bus.out_ready = 1'b1;
        step(19);
        @(negedge clk);
        chk("pp_in_ready_blocked", 160'(bus.in_ready), 160'(0));
        step(1);
        @(negedge clk);
        chk("pp_in_ready_return", 160'(bus.in_ready), 160'(1));
        push_map(img_c);
        step(1);
        bus.heu_out_ready = 1'b0;
        step(45);
        @(negedge clk);
        chk("pp_drained", 160'(sb.size()), 160'(0));
        step(1);

        // backpressure: out_ready pattern 1,0,0,1
        bus.out_ready = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 80; c++)
                img_a[r][c] = 8'((r * 80 + c) * 3 + 7);
        capture(img_a, 1'b1);
        push_map(img_a);
        pat = 4'b1001;
        for (int i = 0; i < 48; i++) begin
            bus.out_ready = pat[i % 4];
            step(1);
        end
        bus.out_ready = 1'b1;
        step(2);
        @(negedge clk);
        chk("bp_drained", 160'(sb.size()), 160'(0));
        step(1);

        // capture on the same edge as the final-row beat
        img_a = fill(8'h5A);
        img_b = fill(8'hA5);
        capture(img_a, 1'b1);
        push_map(img_a);
        step(19);
        capture(img_b, 1'b1);
        push_map(img_b);
        @(negedge clk);
        chk("sim_valid_stays", 160'(bus.out_valid), 160'(1));
        chk("sim_next_row0", 160'(bus.q_row), 160'(0));
        step(22);
        @(negedge clk);
        chk("sim_drained", 160'(sb.size()), 160'(0));
        step(1);

        // reset at row 7 with two images buffered
        bus.out_ready = 1'b0;
        capture(fill(8'h44), 1'b1);
        push_map(fill(8'h44));
        capture(fill(8'h55), 1'b1);
        push_map(fill(8'h55));
        bus.out_ready = 1'b1;
        step(7);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 160'(bus.out_valid), 160'(0));
        chk("mid_rst_in_ready", 160'(bus.in_ready), 160'(1));
        chk("mid_rst_q_row", 160'(bus.q_row), 160'(0));
        step(1);
        rst_n = 1'b1;
        step(30);
        @(negedge clk);
        chk("post_rst_idle", 160'(bus.out_valid), 160'(0));
        step(1);

        // mapping corner: d[4][79] = AB, d[1][0] = CD
        img_corner = '0;
        img_corner[4][79] = 8'hAB;
        img_corner[1][0] = 8'hCD;
        capture(img_corner, 1'b1);
        for (int y = 0; y < 20; y++) begin
            e.q = '0;
            if (y == 4) e.q[0] = 8'hCD;
            if (y == 19) e.q[19] = 8'hAB;
            e.r = 5'(y);
            sb.push_back(e);
        end
        step(22);
        @(negedge clk);
        chk("corner_drained", 160'(sb.size()), 160'(0));
        chk("end_in_ready", 160'(bus.in_ready), 160'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
